// File: rtl/ex_div_ctrl_pkg.sv
// Shared core definitions: divider FSM states, divide funct codes,
// ALU operand-select codes and small operand helpers.
package ex_div_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  // Step counter value loaded at the start of a divide (32 steps: 31..0).
  localparam logic [4:0] DIV_FIRST_STEP = 5'd31;

  // Divider FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_e;

  // Divide/remainder operation codes.
  typedef enum logic [1:0] {
    FN_DIV  = 2'b00,
    FN_DIVU = 2'b01,
    FN_REM  = 2'b10,
    FN_REMU = 2'b11
  } div_funct_e;

  // ALU operand-select codes used by the EX-stage operand muxes.
  typedef enum logic [1:0] {
    OP_SEL_REG = 2'b00,
    OP_SEL_IMM = 2'b01,
    OP_SEL_PC  = 2'b10,
    OP_SEL_FWD = 2'b11
  } alu_op_sel_e;

  // DIV and REM are the signed variants (funct bit 0 clear).
  function automatic logic funct_is_signed(input logic [1:0] f);
    return ~f[0];
  endfunction

  // REM and REMU return the remainder (funct bit 1 set).
  function automatic logic funct_is_rem(input logic [1:0] f);
    return f[1];
  endfunction

  // Magnitude of a two's complement value when en is set, raw value otherwise.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic en);
    return (en && x[XLEN-1]) ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor over 33 bits, emit one quotient bit.
module div_step
  import ex_div_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic            dividend_msb_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            qbit_o
);

  logic [XLEN:0] shifted;

  assign shifted = {rem_i, dividend_msb_i};

  // The trial subtract succeeds when the 33-bit shifted remainder covers the
  // divisor; the accepted difference is then below the divisor, so the low
  // 32 bits of the subtraction are the full new remainder.
  assign qbit_o = (shifted >= {1'b0, divisor_i});
  assign rem_o  = qbit_o ? (shifted[XLEN-1:0] - divisor_i) : shifted[XLEN-1:0];

endmodule

// File: rtl/ex_div_ctrl.sv
// EX-stage iterative divider controller: 32-step restoring divide with sign
// fix-up, single-cycle special cases, pipeline stall and flush handling.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      funct,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e      state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic [XLEN-1:0] quot_q, quot_d;     // dividend shifts out as quotient shifts in
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic [XLEN-1:0] result_q, result_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;

  logic            op_signed;
  logic            div_by_zero;
  logic            signed_ovf;
  logic            step_qbit;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] quot_fixed;
  logic [XLEN-1:0] rem_fixed;
  logic            stall_raw;

  div_step u_div_step (
    .rem_i          (rem_q),
    .dividend_msb_i (quot_q[XLEN-1]),
    .divisor_i      (dvs_q),
    .rem_o          (step_rem),
    .qbit_o         (step_qbit)
  );

  assign op_signed   = funct_is_signed(funct);
  assign div_by_zero = (divisor == '0);
  assign signed_ovf  = op_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
  assign quot_fixed  = neg_quot_q ? (~quot_q + 1'b1) : quot_q;
  assign rem_fixed   = neg_rem_q  ? (~rem_q  + 1'b1) : rem_q;

  // Next-state and output decode; flush overrides every transition.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    result_d   = result_q;
    is_rem_d   = is_rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    stall_raw  = 1'b0;
    busy       = (state_q != ST_IDLE);
    done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall_raw = start;
        if (start && !flush) begin
          is_rem_d   = funct_is_rem(funct);
          neg_quot_d = 1'b0;
          neg_rem_d  = 1'b0;
          if (div_by_zero) begin
            quot_d   = 32'hFFFF_FFFF;
            rem_d    = dividend;
            result_d = funct_is_rem(funct) ? dividend : 32'hFFFF_FFFF;
            state_d  = ST_DONE;
          end else if (signed_ovf) begin
            quot_d   = 32'h8000_0000;
            rem_d    = '0;
            result_d = funct_is_rem(funct) ? '0 : 32'h8000_0000;
            state_d  = ST_DONE;
          end else begin
            quot_d     = abs_val(dividend, op_signed);
            dvs_d      = abs_val(divisor, op_signed);
            rem_d      = '0;
            count_d    = DIV_FIRST_STEP;
            neg_quot_d = op_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_rem_d  = op_signed && dividend[XLEN-1];
            state_d    = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        stall_raw = 1'b1;
        quot_d    = {quot_q[XLEN-2:0], step_qbit};
        rem_d     = step_rem;
        if (count_q == 5'd0) begin
          state_d = ST_FIX;
        end else begin
          count_d = count_q - 5'd1;
        end
      end
      ST_FIX: begin
        stall_raw = 1'b1;
        quot_d    = quot_fixed;
        rem_d     = rem_fixed;
        result_d  = is_rem_q ? rem_fixed : quot_fixed;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  // Stall is forced low while reset is held, whatever start is doing.
  assign stall  = stall_raw & rst_n;
  assign result = result_q;

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      result_q   <= '0;
      is_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      result_q   <= result_d;
      is_rem_q   <= is_rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Self-checking bench for ex_div_ctrl: directed cases with literal results,
// flush/reset scenarios and randomized traffic checked every cycle against
// an operation-level reference model.
module tb_ex_div_ctrl;

  localparam logic [1:0] F_DIV  = 2'b00;
  localparam logic [1:0] F_DIVU = 2'b01;
  localparam logic [1:0] F_REM  = 2'b10;
  localparam logic [1:0] F_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  funct;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  // Reference model state: one operation in flight, counted down in cycles.
  bit          m_active;
  int          m_left;
  logic [31:0] m_result;
  logic [31:0] m_pend;

  always #5 clk = ~clk;

  ex_div_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .funct    (funct),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_special(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!f[0]) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return f[1] ? r : q;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(1, 20));
      4:       v = 32'd0 - 32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Model: normal ops are busy for 33 cycles then DONE; special cases go
  // straight to DONE; flush or reset abandon the operation.
  initial begin
    m_active = 0;
    m_left   = 0;
    m_result = '0;
    m_pend   = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 0;
        m_left   = 0;
        m_result = '0;
      end else if (flush) begin
        m_active = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1;
          m_pend   = ref_div(funct, dividend, divisor);
          if (ref_special(funct, dividend, divisor)) begin
            m_left   = 0;
            m_result = m_pend;
          end else begin
            m_left = 33;
          end
        end
      end else if (m_left == 0) begin
        m_active = 0;
      end else begin
        m_left--;
        if (m_left == 0) m_result = m_pend;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    logic e_done;
    logic e_busy;
    logic e_stall;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      e_done  = m_active && (m_left == 0);
      e_busy  = m_active;
      e_stall = rst_n && (m_active ? (m_left != 0) : start);
      check("done",   32'(done),  32'(e_done));
      check("busy",   32'(busy),  32'(e_busy));
      check("stall",  32'(stall), 32'(e_stall));
      check("result", result,     m_result);
    end
  end

  // Issue one operation from IDLE and check its result and latency literally.
  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    int n;
    funct    = f;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    // done is consumed at the edge after it rises, hence n+1
    check("op_latency", 32'(n + 1), 32'(exp_lat));
    check("op_result", result, exp_res);
    $display("op funct=%0d a=0x%08h b=0x%08h -> result=0x%08h latency=%0d", f, a, b, result, n + 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int saved;
    int n;
    rst_n    = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    funct    = 2'b00;
    dividend = '0;
    divisor  = '0;

    // Reference model pinned to hand-computed values.
    check("ref_divu_100_7", ref_div(F_DIVU, 32'd100, 32'd7), 32'd14);
    check("ref_div_m7_2",   ref_div(F_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("ref_rem_m7_2",   ref_div(F_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    repeat (3) @(posedge clk);
    #1;
    check("rst_done",   32'(done),  32'd0);
    check("rst_busy",   32'(busy),  32'd0);
    check("rst_stall",  32'(stall), 32'd0);
    check("rst_result", result,     32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(F_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_op(F_REMU, 32'd100, 32'd7, 32'd2, 34);
    run_op(F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op(F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op(F_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op(F_REM,  32'd5, 32'd0, 32'd5, 1);
    run_op(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op(F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
    run_op(F_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);

    // Flush at CALC cycle 10: back to IDLE, no done pulse, then a clean op.
    funct = F_DIVU; dividend = 32'd12345; divisor = 32'd67; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    saved = done_cnt;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    repeat (40) begin @(posedge clk); #1; end
    check("flush_no_done", 32'(done_cnt), 32'(saved));
    $display("flush at CALC cycle 10: busy=%0d done pulses after=%0d", busy, done_cnt - saved);
    run_op(F_DIVU, 32'd1000, 32'd10, 32'd100, 34);

    // Reset at CALC cycle 20 with start held: outputs drop at once, no done later.
    funct = F_DIV; dividend = 32'hFFFF_0000; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_done",   32'(done),  32'd0);
    check("midrst_busy",   32'(busy),  32'd0);
    check("midrst_stall",  32'(stall), 32'd0);
    check("midrst_result", result,     32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    rst_n = 1'b1;
    saved = done_cnt;
    repeat (40) begin @(posedge clk); #1; end
    check("midrst_no_done", 32'(done_cnt), 32'(saved));
    $display("reset at CALC cycle 20: done pulses after=%0d", done_cnt - saved);

    // start held through CALC and DONE: only one operation runs.
    funct = F_DIVU; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    saved = done_cnt;
    @(posedge clk); #1;
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    check("held_latency", 32'(n + 1), 32'd34);
    check("held_result", result, 32'd10);
    @(posedge clk); #1;
    start = 1'b0;
    check("held_no_relaunch", 32'(busy), 32'd0);
    repeat (40) begin @(posedge clk); #1; end
    check("held_one_done", 32'(done_cnt), 32'(saved + 1));
    $display("start held: latency=%0d done pulses=%0d", n + 1, done_cnt - saved);

    // Randomized traffic with occasional flush and reset.
    repeat (4000) begin
      @(posedge clk); #1;
      rst_n    = ($urandom_range(0, 499) != 0);
      start    = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 119) == 0);
      funct    = 2'($urandom_range(0, 3));
      dividend = pick_operand();
      divisor  = pick_operand();
      if (done) $display("random op done: result=0x%08h expected=0x%08h", result, m_result);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_div_ctrl.md
EX_DIV_CTRL -- requirements
Module: ex_div_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, EX-stage request to begin a divide; sampled only in IDLE.
REQ-004 SHALL have port funct, input, 2, operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; captured with start.
REQ-005 SHALL have ports dividend and divisor, input, 32 each, operands from the forwarded ALU operand path; captured with start.
REQ-006 SHALL have port flush, input, 1, pipeline kill; aborts any operation in progress.
REQ-007 SHALL have port stall, output, 1, holds IF/ID/EX while the divide is in progress.
REQ-008 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking result valid.
REQ-010 SHALL have port result, output, 32, quotient or remainder per captured funct.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-012 IDLE: start=1 and flush=0 SHALL capture operands and funct, load |dividend| and |divisor| (unsigned ops: raw values), clear the remainder register, set count=31, and go to CALC.
REQ-013 IDLE with start=1 and divisor=0 SHALL go directly to DONE: quotient=0xFFFFFFFF, remainder=dividend.
REQ-014 IDLE with start=1, funct=DIV or REM, dividend=0x80000000, divisor=0xFFFFFFFF SHALL go directly to DONE: quotient=0x80000000, remainder=0.
REQ-015 CALC SHALL perform one restoring shift-subtract step per cycle (33-bit trial subtract); count decrements each cycle; after the step with count=0 (32 steps), go to FIX.
REQ-016 FIX SHALL negate the quotient when signed and operand signs differ, negate the remainder when signed and dividend is negative, then go to DONE.
REQ-017 DONE SHALL assert done for exactly one cycle, drive result (quotient for DIV/DIVU, remainder for REM/REMU), and return to IDLE.
REQ-018 Normal latency SHALL be 34 cycles from the start-sampling edge to done; the special cases of REQ-013/014 SHALL take 1 cycle.
REQ-019 stall SHALL equal (start & IDLE) | CALC | FIX; it SHALL be low in DONE so the pipeline advances in the same cycle the result is consumed.
REQ-020 start SHALL be ignored outside IDLE; start in DONE SHALL NOT launch a new operation until the next IDLE cycle.
REQ-021 flush in any state SHALL force IDLE on the next edge with no done pulse; flush in the same cycle as start in IDLE SHALL leave the FSM in IDLE.
REQ-022 result SHALL hold its last value outside DONE; done SHALL be 0 outside DONE.

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, count=0, quotient, remainder, and result=0, and stall=busy=done=0.
REQ-024 Reset asserted mid-operation SHALL discard the operation; no done SHALL follow deassertion.

Structure
REQ-025 State encoding (2-bit) and funct codes SHALL live in the shared core package, alongside the ALU operand-select codes.
REQ-026 One sub-module, div_step (combinational 33-bit trial subtract, one quotient bit out), is natural; the FSM and registers stay in ex_div_ctrl.

Verification
REQ-027 DIVU 100/7: start -> done 34 cycles later, result=14; REMU gives 2.
REQ-028 DIV -7/2 -> result=0xFFFFFFFD (-3); REM -7/2 -> result=0xFFFFFFFF (-1).
REQ-029 DIV 5/0 -> done after 1 cycle, result=0xFFFFFFFF; REM 5/0 -> result=5.
REQ-030 DIV 0x80000000/0xFFFFFFFF -> done after 1 cycle, result=0x80000000; REM -> result=0.
REQ-031 flush at cycle 10 of CALC -> IDLE next cycle, no done pulse; a new start then completes normally.
REQ-032 rst_n low at cycle 20 of CALC -> outputs 0 immediately; start held high through CALC -> no second operation launched.
